// File: rtl/maxpool_2x2_stream_if.sv
// Conv-to-pool stream bundle: controller enable, conv pixel stream in, pooled pixel stream out.
interface maxpool_2x2_stream_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_CH = 32
);
  logic                       pooling_ctrl;
  logic                       conv_valid;
  logic [NUM_CH*DATA_W-1:0]   conv_data;
  logic                       pool_valid;
  logic [NUM_CH*DATA_W-1:0]   pool_data;
  logic                       pooling_finish;
  logic                       busy;

  modport master (
    output pooling_ctrl, conv_valid, conv_data,
    input  pool_valid, pool_data, pooling_finish, busy
  );

  modport slave (
    input  pooling_ctrl, conv_valid, conv_data,
    output pool_valid, pool_data, pooling_finish, busy
  );
endinterface

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a row-major conv output map, NUM_CH lanes in parallel.
// Even rows fold pixel pairs into a half-width line buffer; odd rows close each window.
module maxpool_2x2_stream #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_CH = 32,
  parameter int unsigned FMAP_W = 28,
  parameter int unsigned FMAP_H = 28
) (
  input logic                 clk,
  input logic                 nrst,
  maxpool_2x2_stream_if.slave bus
);
  localparam int unsigned BUS_W    = NUM_CH * DATA_W;
  localparam int unsigned COL_W    = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
  localparam int unsigned ROW_W    = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
  localparam int unsigned LB_DEPTH = (FMAP_W > 1) ? FMAP_W / 2 : 1;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FMAP_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FMAP_H - 1);

  if ((FMAP_W < 2) || ((FMAP_W % 2) != 0) || (FMAP_H < 2) || ((FMAP_H % 2) != 0)) begin : g_bad_fmap
    $error("maxpool_2x2_stream: FMAP_W and FMAP_H must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [DATA_W-1:0] pmax [NUM_CH];
  logic [BUS_W-1:0]         linebuf [LB_DEPTH];

  logic                     accept_c;
  logic                     last_px_c;
  logic [LB_AW-1:0]         lb_idx_c;
  logic [BUS_W-1:0]         lb_rd_c;
  logic [BUS_W-1:0]         pair_max_c;
  logic [BUS_W-1:0]         win_max_c;

  assign accept_c  = (state == S_RUN) && bus.pooling_ctrl && bus.conv_valid;
  assign last_px_c = (col == COL_LAST) && (row == ROW_LAST);
  assign lb_idx_c  = LB_AW'(col >> 1);
  assign lb_rd_c   = linebuf[lb_idx_c];

  // Per-lane signed max of the horizontal pair, then against the buffered upper pair.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic signed [DATA_W-1:0] d;
    logic signed [DATA_W-1:0] lb;
    logic signed [DATA_W-1:0] m;
    assign d  = bus.conv_data[k*DATA_W +: DATA_W];
    assign lb = lb_rd_c[k*DATA_W +: DATA_W];
    assign m  = (d > pmax[k]) ? d : pmax[k];
    assign pair_max_c[k*DATA_W +: DATA_W] = m;
    assign win_max_c[k*DATA_W +: DATA_W]  = (lb > m) ? lb : m;
  end

  // Line buffer has no reset: every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (accept_c && col[0] && !row[0]) begin
      linebuf[lb_idx_c] <= pair_max_c;
    end
  end

  // Control FSM, position counters, pair register and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state              <= S_IDLE;
      col                <= '0;
      row                <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) pmax[k] <= '0;
      bus.pool_data      <= '0;
      bus.pool_valid     <= 1'b0;
      bus.pooling_finish <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      bus.pool_valid     <= 1'b0;
      bus.pooling_finish <= 1'b0;
      case (state)
        S_IDLE: begin
          col <= '0;
          row <= '0;
          if (bus.pooling_ctrl) begin
            state    <= S_RUN;
            bus.busy <= 1'b1;
          end
        end
        S_RUN: begin
          if (!bus.pooling_ctrl) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
            col      <= '0;
            row      <= '0;
          end else if (bus.conv_valid) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (!col[0]) begin
              for (int unsigned k = 0; k < NUM_CH; k++) pmax[k] <= bus.conv_data[k*DATA_W +: DATA_W];
            end else if (row[0]) begin
              bus.pool_data  <= win_max_c;
              bus.pool_valid <= 1'b1;
              if (last_px_c) begin
                bus.pooling_finish <= 1'b1;
                bus.busy           <= 1'b0;
                state              <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          if (!bus.pooling_ctrl) state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Bench for maxpool_2x2_stream on a 4x4 map with two lanes; expected strobes come from a
// window-max model over the stimulus image.
module tb_maxpool_2x2_stream;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned FMAP_W = 4;
  localparam int unsigned FMAP_H = 4;
  localparam int unsigned BUS_W  = NUM_CH * DATA_W;
  localparam int PIX  = int'(FMAP_W * FMAP_H);
  localparam int NOUT = int'((FMAP_W / 2) * (FMAP_H / 2));

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  maxpool_2x2_stream_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

  maxpool_2x2_stream #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .FMAP_W(FMAP_W), .FMAP_H(FMAP_H)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  logic signed [DATA_W-1:0] img [NUM_CH][PIX];
  int                       drv_cyc [PIX];
  logic [BUS_W-1:0]         cap_data [$];
  int                       cap_cyc  [$];
  bit                       cap_fin  [$];
  logic [BUS_W-1:0]         exp_data [$];
  int                       exp_idx  [$];
  int                       cyc = 0;
  int                       checks = 0;
  int                       errors = 0;
  int                       stray_fin = 0;
  logic                     busy_mid;

  // Strobe monitor, sampling 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (bus.pool_valid === 1'b1) begin
      cap_data.push_back(bus.pool_data);
      cap_cyc.push_back(cyc);
      cap_fin.push_back(bus.pooling_finish === 1'b1);
    end else if (bus.pooling_finish !== 1'b0) begin
      stray_fin++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [BUS_W-1:0] pack_px(input int i);
    logic [BUS_W-1:0] v;
    for (int c = 0; c < int'(NUM_CH); c++) v[c*DATA_W +: DATA_W] = img[c][i];
    return v;
  endfunction

  // mode 0: lane0 = 0..15, lane1 = 100-lane0; mode 1: lane0 = -1..-16, lane1 random; else random
  task automatic fill_img(input int mode);
    for (int i = 0; i < PIX; i++) begin
      case (mode)
        0:       begin img[0][i] = DATA_W'(i);      img[1][i] = DATA_W'(100 - i); end
        1:       begin img[0][i] = DATA_W'(-1 - i); img[1][i] = DATA_W'($urandom); end
        default: begin img[0][i] = DATA_W'($urandom); img[1][i] = DATA_W'($urandom); end
      endcase
    end
  endtask

  // Reference: every 2x2 window whose bottom-right pixel falls among the first n_acc accepted pixels.
  task automatic build_expected(input int n_acc);
    logic [BUS_W-1:0] v;
    int base;
    exp_data.delete();
    exp_idx.delete();
    for (int py = 0; py < int'(FMAP_H / 2); py++) begin
      for (int px = 0; px < int'(FMAP_W / 2); px++) begin
        base = 2 * py * int'(FMAP_W) + 2 * px;
        if (base + int'(FMAP_W) + 1 < n_acc) begin
          for (int c = 0; c < int'(NUM_CH); c++)
            v[c*DATA_W +: DATA_W] = smax(smax(img[c][base], img[c][base + 1]),
                                         smax(img[c][base + int'(FMAP_W)], img[c][base + int'(FMAP_W) + 1]));
          exp_data.push_back(v);
          exp_idx.push_back(base + int'(FMAP_W) + 1);
        end
      end
    end
  endtask

  task automatic clear_capture();
    cap_data.delete();
    cap_cyc.delete();
    cap_fin.delete();
  endtask

  task automatic start_map();
    clear_capture();
    @(negedge clk);
    bus.pooling_ctrl = 1'b1;
    bus.conv_valid   = 1'b0;
  endtask

  // gap >= 0: fixed bubble count after each pixel; gap < 0: random 0..2 bubbles
  task automatic drive_pixels(input int first, input int last_ex, input int gap);
    int g;
    for (int i = first; i < last_ex; i++) begin
      @(negedge clk);
      if (i == 1) busy_mid = bus.busy;
      bus.conv_valid = 1'b1;
      bus.conv_data  = pack_px(i);
      drv_cyc[i]     = cyc;
      g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
      repeat (g) begin
        @(negedge clk);
        bus.conv_valid = 1'b0;
        bus.conv_data  = BUS_W'({$urandom, $urandom});
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    bus.conv_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic stop_map();
    @(negedge clk);
    bus.pooling_ctrl = 1'b0;
    bus.conv_valid   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_map(input string name, input int gap, input bit hold);
    logic [BUS_W-1:0] got;
    build_expected(PIX);
    start_map();
    drive_pixels(0, PIX, gap);
    settle();
    checks++;
    if (busy_mid !== 1'b1) begin errors++; $display("FAIL %s_busy_run: got %b expected 1", name, busy_mid); end
    checks++;
    if (cap_data.size() != NOUT) begin
      errors++; $display("FAIL %s_count: got %0d strobes expected %0d", name, cap_data.size(), NOUT);
    end
    for (int k = 0; k < exp_data.size(); k++) begin
      got = (k < cap_data.size()) ? cap_data[k] : 'x;
      checks++;
      if (got !== exp_data[k]) begin
        errors++; $display("FAIL %s_data[%0d]: got %h expected %h", name, k, got, exp_data[k]);
      end
      if (k < cap_data.size()) begin
        checks++;
        if (cap_cyc[k] != drv_cyc[exp_idx[k]] + 1) begin
          errors++; $display("FAIL %s_latency[%0d]: strobe cycle %0d expected %0d", name, k, cap_cyc[k], drv_cyc[exp_idx[k]] + 1);
        end
        checks++;
        if (cap_fin[k] != (k == NOUT - 1)) begin
          errors++; $display("FAIL %s_finish[%0d]: got %b expected %b", name, k, cap_fin[k], (k == NOUT - 1));
        end
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy_done: got %b expected 0", name, bus.busy); end
    if (!hold) stop_map();
  endtask

  task automatic test_reset();
    bus.pooling_ctrl = 1'b0;
    bus.conv_valid   = 1'b0;
    bus.conv_data    = '0;
    nrst = 1'b0;
    #12;
    checks++;
    if ({bus.pool_valid, bus.pooling_finish, bus.busy} !== 3'b000 || bus.pool_data !== '0) begin
      errors++; $display("FAIL reset_outputs: got valid=%b finish=%b busy=%b data=%h expected all 0",
                         bus.pool_valid, bus.pooling_finish, bus.busy, bus.pool_data);
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_basic();
    int ref0 [4] = '{5, 7, 13, 15};
    int ref1 [4] = '{100, 98, 92, 90};
    logic [BUS_W-1:0] got;
    logic [BUS_W-1:0] want;
    fill_img(0);
    test_full_map("basic", 0, 1'b0);
    for (int k = 0; k < NOUT; k++) begin
      got  = (k < cap_data.size()) ? cap_data[k] : 'x;
      want = {DATA_W'(ref1[k]), DATA_W'(ref0[k])};
      checks++;
      if (got !== want) begin errors++; $display("FAIL basic_const[%0d]: got %h expected %h", k, got, want); end
    end
  endtask

  task automatic test_negative();
    int ref0 [4] = '{-1, -3, -9, -11};
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] want;
    fill_img(1);
    test_full_map("negative", 0, 1'b0);
    for (int k = 0; k < NOUT; k++) begin
      got  = (k < cap_data.size()) ? cap_data[k][DATA_W-1:0] : 'x;
      want = DATA_W'(ref0[k]);
      checks++;
      if (got !== want) begin errors++; $display("FAIL negative_const[%0d]: got %h expected %h", k, got, want); end
    end
  endtask

  task automatic test_gaps();
    fill_img(0);
    test_full_map("gap1", 1, 1'b0);
  endtask

  task automatic test_abort();
    fill_img(0);
    build_expected(10);
    start_map();
    drive_pixels(0, 10, 0);
    settle();
    stop_map();
    checks++;
    if (cap_data.size() != 2) begin errors++; $display("FAIL abort_count: got %0d strobes expected 2", cap_data.size()); end
    for (int k = 0; k < cap_data.size() && k < exp_data.size(); k++) begin
      checks++;
      if (cap_data[k] !== exp_data[k] || cap_fin[k]) begin
        errors++; $display("FAIL abort_data[%0d]: got %h fin=%b expected %h fin=0", k, cap_data[k], cap_fin[k], exp_data[k]);
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    test_full_map("abort_restart", 0, 1'b0);
  endtask

  task automatic test_simultaneous_abort();
    fill_img(2);
    build_expected(PIX - 1);
    start_map();
    drive_pixels(0, PIX - 1, 0);
    @(negedge clk);
    bus.pooling_ctrl = 1'b0;
    bus.conv_valid   = 1'b1;
    bus.conv_data    = pack_px(PIX - 1);
    settle();
    checks++;
    if (cap_data.size() != NOUT - 1) begin
      errors++; $display("FAIL simul_count: got %0d strobes expected %0d", cap_data.size(), NOUT - 1);
    end
    for (int k = 0; k < cap_data.size() && k < exp_data.size(); k++) begin
      checks++;
      if (cap_data[k] !== exp_data[k] || cap_fin[k]) begin
        errors++; $display("FAIL simul_data[%0d]: got %h fin=%b expected %h fin=0", k, cap_data[k], cap_fin[k], exp_data[k]);
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL simul_busy: got %b expected 0", bus.busy); end
    test_full_map("simul_restart", 0, 1'b0);
  endtask

  task automatic test_done_hold();
    fill_img(2);
    test_full_map("done_map", 0, 1'b1);
    clear_capture();
    drive_pixels(0, PIX, 0);
    settle();
    checks++;
    if (cap_data.size() != 0) begin errors++; $display("FAIL done_ignores_input: got %0d strobes expected 0", cap_data.size()); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b expected 0", bus.busy); end
    stop_map();
    fill_img(2);
    test_full_map("done_reenable", -1, 1'b0);
  endtask

  task automatic test_reset_mid_map();
    fill_img(0);
    start_map();
    drive_pixels(0, 8, 0);
    @(negedge clk);
    bus.conv_valid = 1'b0;
    #1 nrst = 1'b0;
    #1;
    checks++;
    if ({bus.pool_valid, bus.pooling_finish, bus.busy} !== 3'b000 || bus.pool_data !== '0) begin
      errors++; $display("FAIL midreset_outputs: got valid=%b finish=%b busy=%b data=%h expected all 0",
                         bus.pool_valid, bus.pooling_finish, bus.busy, bus.pool_data);
    end
    bus.pooling_ctrl = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    test_full_map("after_reset", 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      fill_img(2);
      test_full_map($sformatf("random%0d", r), -1, 1'b0);
    end
    checks++;
    if (stray_fin != 0) begin errors++; $display("FAIL stray_finish: got %0d finish pulses without valid expected 0", stray_fin); end
  endtask

  initial begin
    busy_mid = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_gaps();
    test_abort();
    test_simultaneous_abort();
    test_done_hold();
    test_reset_mid_map();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
